// File: rtl/fifo_drain_arb_if.sv
// Source-FIFO read side and output word stream of fifo_drain_arb.
// out_src exists only when DRAIN_SRC_TAG_EN is defined.
interface fifo_drain_arb_if #(
   parameter int C_WIDTH   = 8,
   parameter int C_NUM_SRC = 4
);
   logic [C_NUM_SRC-1:0]         fifo_empty;
   logic [C_NUM_SRC*C_WIDTH-1:0] fifo_data;
   logic [C_NUM_SRC-1:0]         fifo_rd_en;
   logic [C_WIDTH-1:0]           out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         busy;
`ifdef DRAIN_SRC_TAG_EN
   logic [$clog2(C_NUM_SRC)-1:0] out_src;

   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_rd_en, out_data, out_valid, busy, out_src
   );
   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_rd_en, out_data, out_valid, busy, out_src
   );
`else
   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_rd_en, out_data, out_valid, busy
   );
   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_rd_en, out_data, out_valid, busy
   );
`endif
endinterface

// File: rtl/fifo_drain_arb.sv
// Round-robin burst arbiter draining C_NUM_SRC zero-when-idle FIFOs into one stream.
// Define DRAIN_SRC_TAG_EN to carry the source index (out_src) alongside each word.
module fifo_drain_arb #(
   parameter int C_WIDTH   = 8,
   parameter int C_NUM_SRC = 4,
   parameter int C_SRC_W   = 2,
   parameter int C_BURST   = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_drain_arb_if.master  bus
);
   localparam int C_CNT_W = (C_BURST > 1) ? $clog2(C_BURST) : 1;

   typedef enum logic {IDLE, BURST} state_e;

   state_e               state_q, state_d;
   logic [C_SRC_W-1:0]   gnt_q, gnt_d;
   logic [C_SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [C_SRC_W-1:0]   infl_src_q, infl_src_d;
   logic [C_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic                 inflight_q, inflight_d;
   logic [C_WIDTH-1:0]   out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic [C_WIDTH-1:0]   skid_data_q, skid_data_d;
   logic                 skid_valid_q, skid_valid_d;
`ifdef DRAIN_SRC_TAG_EN
   logic [C_SRC_W-1:0]   out_src_q, out_src_d;
   logic [C_SRC_W-1:0]   skid_src_q, skid_src_d;
`endif

   logic [C_NUM_SRC-1:0]   rd_en;
   logic [2*C_NUM_SRC-1:0] avail_dbl;
   logic [C_NUM_SRC-1:0]   avail_rot;
   logic                   found;
   logic [C_SRC_W-1:0]     scan_off;
   logic [C_SRC_W:0]       scan_sum;
   logic [C_SRC_W-1:0]     nxt_src;
   logic [C_SRC_W-1:0]     gnt_inc;
   logic                   xfer;
   logic [1:0]             pend;
   logic                   credit_ok;
   logic                   last_beat;
   logic [C_WIDTH-1:0]     ret_word;

   // Rotate availability so bit 0 is the source at rr_ptr.
   assign avail_dbl = {~bus.fifo_empty, ~bus.fifo_empty};
   assign avail_rot = C_NUM_SRC'(avail_dbl >> rr_ptr_q);

   always_comb begin
      found    = 1'b0;
      scan_off = '0;
      for (int i = 0; i < C_NUM_SRC; i++) begin
         if (!found && avail_rot[i]) begin
            found    = 1'b1;
            scan_off = C_SRC_W'(i);
         end
      end
      scan_sum = {1'b0, rr_ptr_q} + {1'b0, scan_off};
      if (scan_sum >= (C_SRC_W+1)'(C_NUM_SRC)) begin
         scan_sum = scan_sum - (C_SRC_W+1)'(C_NUM_SRC);
      end
      nxt_src = scan_sum[C_SRC_W-1:0];
   end

   assign gnt_inc = (gnt_q == C_SRC_W'(C_NUM_SRC-1)) ? '0 : gnt_q + 1'b1;

   assign xfer      = out_valid_q && bus.out_ready;
   assign pend      = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                    + {1'b0, inflight_q};
   // Slots already promised (held plus in flight) must leave room for one more.
   assign credit_ok = (pend - {1'b0, xfer}) < 2'd2;
   assign last_beat = (beat_cnt_q == C_CNT_W'(C_BURST-1));
   assign ret_word  = bus.fifo_data[infl_src_q*C_WIDTH +: C_WIDTH];

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      rd_en      = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d      = nxt_src;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            if (bus.fifo_empty[gnt_q]) begin
               state_d  = IDLE;
               rr_ptr_d = gnt_inc;
            end else if (credit_ok) begin
               rd_en[gnt_q] = 1'b1;
               beat_cnt_d   = beat_cnt_q + 1'b1;
               if (last_beat) begin
                  state_d  = IDLE;
                  rr_ptr_d = gnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign inflight_d = |rd_en;
   assign infl_src_d = gnt_q;

   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
`ifdef DRAIN_SRC_TAG_EN
      out_src_d    = out_src_q;
      skid_src_d   = skid_src_q;
`endif
      if (xfer) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_data_d  = '0;
            skid_valid_d = 1'b0;
`ifdef DRAIN_SRC_TAG_EN
            out_src_d    = skid_src_q;
            skid_src_d   = '0;
`endif
         end else begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
`ifdef DRAIN_SRC_TAG_EN
            out_src_d   = '0;
`endif
         end
      end
      if (inflight_q) begin
         if (!out_valid_d) begin
            out_data_d  = ret_word;
            out_valid_d = 1'b1;
`ifdef DRAIN_SRC_TAG_EN
            out_src_d   = infl_src_q;
`endif
         end else begin
            skid_data_d  = ret_word;
            skid_valid_d = 1'b1;
`ifdef DRAIN_SRC_TAG_EN
            skid_src_d   = infl_src_q;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         infl_src_q   <= '0;
         beat_cnt_q   <= '0;
         inflight_q   <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
`ifdef DRAIN_SRC_TAG_EN
         out_src_q    <= '0;
         skid_src_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         infl_src_q   <= infl_src_d;
         beat_cnt_q   <= beat_cnt_d;
         inflight_q   <= inflight_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
`ifdef DRAIN_SRC_TAG_EN
         out_src_q    <= out_src_d;
         skid_src_q   <= skid_src_d;
`endif
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = (state_q != IDLE) || inflight_q
                        || out_valid_q || skid_valid_q;
`ifdef DRAIN_SRC_TAG_EN
   assign bus.out_src    = out_src_q;
`endif

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed bench for fifo_drain_arb with behavioural zero-when-idle source FIFOs.
// Build with DRAIN_SRC_TAG_EN defined to also check out_src.
module tb_fifo_drain_arb;
   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_drain_arb_if #(.C_WIDTH(W), .C_NUM_SRC(N)) bus ();

   fifo_drain_arb #(
      .C_WIDTH(W), .C_NUM_SRC(N), .C_SRC_W(2), .C_BURST(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [W-1:0] mem [N][64];
   int           wr_cnt [N];
   int           rd_cnt [N];
   logic [W-1:0] ret [N];
   int           rd_total;
   int           overread;
   int           cyc;
   logic [W-1:0] got [$];
   int           got_cyc [$];
   logic [1:0]   got_src [$];
   int           checks = 0;
   int           errors = 0;

   for (genvar g = 0; g < N; g++) begin : g_src
      assign bus.fifo_empty[g]        = (wr_cnt[g] == rd_cnt[g]);
      assign bus.fifo_data[g*W +: W]  = ret[g];
   end

   // Source FIFO model plus output monitor.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            rd_cnt[i] <= wr_cnt[i];
            ret[i]    <= '0;
         end else if (bus.fifo_rd_en[i] && wr_cnt[i] != rd_cnt[i]) begin
            ret[i]    <= mem[i][rd_cnt[i]];
            rd_cnt[i] <= rd_cnt[i] + 1;
         end else begin
            ret[i] <= '0;
            if (bus.fifo_rd_en[i]) overread <= overread + 1;
         end
      end
      if (!rst && |bus.fifo_rd_en) rd_total <= rd_total + 1;
      if (!rst && bus.out_valid && bus.out_ready) begin
         got.push_back(bus.out_data);
         got_cyc.push_back(cyc);
`ifdef DRAIN_SRC_TAG_EN
         got_src.push_back(bus.out_src);
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int s, input logic [W-1:0] v);
      mem[s][wr_cnt[s]] = v;
      wr_cnt[s] = wr_cnt[s] + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      got.delete();
      got_cyc.delete();
      got_src.delete();
      rst = 1'b0;
   endtask

   task automatic wait_words(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         step(1);
         k++;
      end
      check(tag, got.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r0;
      logic [7:0] exp_w;
      bus.out_ready = 1'b1;

      // Reset state
      step(2);
      check("rst_rd_en", bus.fifo_rd_en, 4'b0000);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      rst = 1'b0;

      // Scenario 1: src0 holds three words
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      step(1);
      check("s1_rd_en_first", bus.fifo_rd_en, 4'b0001);
      check("s1_valid_c1", bus.out_valid, 1'b0);
      step(1);
      check("s1_valid_c2", bus.out_valid, 1'b0);
      step(1);
      check("s1_word0", {bus.out_valid, bus.out_data}, 9'h111);
      step(1);
      check("s1_word1", {bus.out_valid, bus.out_data}, 9'h122);
      step(1);
      check("s1_word2", {bus.out_valid, bus.out_data}, 9'h133);
      step(1);
      check("s1_valid_end", bus.out_valid, 1'b0);
      check("s1_busy_end", bus.busy, 1'b0);
      check("s1_rr_ptr", 32'(dut.rr_ptr_q), 1);
      check("s1_out_data_idle", bus.out_data, 8'h00);

      // Scenario 2: four sources, eight words each
      do_reset();
      for (int s = 0; s < N; s++)
         for (int n = 0; n < 8; n++)
            push(s, 8'(s*16 + n));
      r0 = rd_total;
      wait_words("s2_count", 32, 400);
      for (int k = 0; k < 32; k++) begin
         exp_w = 8'(((k/4)%4)*16 + (k/16)*4 + (k%4));
         check($sformatf("s2_word%0d", k), (k < got.size()) ? got[k] : 8'hxx,
               exp_w);
`ifdef DRAIN_SRC_TAG_EN
         check($sformatf("s2_tag%0d", k),
               (k < got_src.size()) ? got_src[k] : 2'bxx, 2'((k/4)%4));
`endif
      end
      check("s2_rd_total", rd_total - r0, 32);
      step(2);
      check("s2_busy_end", bus.busy, 1'b0);
      check("s2_overread", overread, 0);

      // Scenario 3: src2 streaming under a 10-cycle stall
      do_reset();
      bus.out_ready = 1'b0;
      for (int n = 0; n < 8; n++) push(2, 8'(8'h20 + n));
      r0 = rd_total;
      step(10);
      check("s3_stall_rd", rd_total - r0, 2);
      check("s3_stall_rd_en", bus.fifo_rd_en, 4'b0000);
      check("s3_stall_head", {bus.out_valid, bus.out_data}, 9'h120);
      check("s3_stall_none_out", got.size(), 0);
      check("s3_stall_busy", bus.busy, 1'b1);
      bus.out_ready = 1'b1;
      wait_words("s3_count", 8, 100);
      for (int k = 0; k < 8; k++)
         check($sformatf("s3_word%0d", k), (k < got.size()) ? got[k] : 8'hxx,
               8'(8'h20 + k));
      if (got_cyc.size() >= 3) begin
         check("s3_gap01", got_cyc[1] - got_cyc[0], 1);
         check("s3_gap12", got_cyc[2] - got_cyc[1], 1);
      end
      check("s3_rd_total", rd_total - r0, 8);

      // Scenario 4: only src3, one word, pointer wraps
      do_reset();
      check("s4_rr_reset", 32'(dut.rr_ptr_q), 0);
      push(3, 8'h3A);
      r0 = rd_total;
      step(1);
      check("s4_rd_en", bus.fifo_rd_en, 4'b1000);
      step(5);
      check("s4_rd_once", rd_total - r0, 1);
      check("s4_count", got.size(), 1);
      check("s4_word", (got.size() > 0) ? got[0] : 8'hxx, 8'h3A);
`ifdef DRAIN_SRC_TAG_EN
      check("s4_tag", (got_src.size() > 0) ? got_src[0] : 2'bxx, 2'd3);
`endif
      check("s4_rr_wrap", 32'(dut.rr_ptr_q), 0);
      check("s4_busy_end", bus.busy, 1'b0);

      // Scenario 5: reset the cycle after a read is issued
      do_reset();
      for (int n = 0; n < 4; n++) push(1, 8'(8'h40 + n));
      step(1);
      check("s5_rd_en", bus.fifo_rd_en, 4'b0010);
      step(1);
      rst = 1'b1;
      step(1);
      check("s5_out_valid", bus.out_valid, 1'b0);
      check("s5_rd_en_rst", bus.fifo_rd_en, 4'b0000);
      check("s5_out_data", bus.out_data, 8'h00);
      check("s5_busy", bus.busy, 1'b0);
      check("s5_state", 32'(dut.state_q), 0);
      rst = 1'b0;
      step(5);
      check("s5_no_words", got.size(), 0);
      check("s5_overread", overread, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
